// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with tick-based debounce.
// One row strobe walks across the keypad per scan tick. A press is accepted
// after DEBOUNCE_TICKS stable ticks and a release after DEBOUNCE_TICKS idle ticks.
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat every REPEAT_TICKS
// ticks while the accepted key stays held.
module keypad_scan #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 32
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       clk_e,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2} state_t;

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_TICKS);

    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15) begin : g_db_range
        $error("DEBOUNCE_TICKS must be in 1..15");
    end
    if (REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_rpt_range
        $error("REPEAT_TICKS must be in 1..255");
    end

    // Lowest-numbered low column wins.
    function automatic logic [1:0] col_index(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        if (!c[0])      idx = 2'd0;
        else if (!c[1]) idx = 2'd1;
        else if (!c[2]) idx = 2'd2;
        else if (!c[3]) idx = 2'd3;
        return idx;
    endfunction

    // Active-low one-cold row strobe for row index r.
    function automatic logic [3:0] row_decode(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    state_t     state, state_nx;
    logic       clk_en_q;
    logic [3:0] col_meta, col_s;
    logic [1:0] row_idx, row_idx_nx;
    logic [3:0] pat, pat_nx;
    logic [3:0] cnt, cnt_nx;
    logic [3:0] rel_cnt, rel_cnt_nx;
    logic [3:0] code_nx;
    logic       valid_nx, held_nx, accept;
    logic       tick, pressed;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] RPT_LIMIT = 8'(REPEAT_TICKS);
    logic [7:0] rpt_cnt, rpt_cnt_nx;
`endif

    assign tick    = clk_e & ~clk_en_q;
    assign pressed = (col_s != 4'b1111);

    // Edge-detect the scan enable and synchronize the asynchronous column returns.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_en_q <= 1'b0;
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            clk_en_q <= clk_e;
            col_meta <= COL;
            col_s    <= col_meta;
        end
    end

    // Next-state and output decode; everything except the valid pulse moves only on a tick.
    always_comb begin
        state_nx   = state;
        row_idx_nx = row_idx;
        pat_nx     = pat;
        cnt_nx     = cnt;
        rel_cnt_nx = rel_cnt;
        code_nx    = key_code;
        valid_nx   = 1'b0;
        held_nx    = key_held;
        accept     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_nx = rpt_cnt;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (pressed) begin
                        pat_nx   = col_s;
                        cnt_nx   = 4'd1;
                        state_nx = DEBOUNCE;
                        accept   = (DB_LIMIT == 4'd1);
                    end else begin
                        row_idx_nx = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!pressed) begin
                        state_nx   = SCAN;
                        row_idx_nx = row_idx + 2'd1;
                    end else begin
                        if (col_s == pat) begin
                            cnt_nx = cnt + 4'd1;
                        end else begin
                            pat_nx = col_s;
                            cnt_nx = 4'd1;
                        end
                        accept = (cnt_nx == DB_LIMIT);
                    end
                end
                HELD: begin
                    rel_cnt_nx = pressed ? 4'd0 : rel_cnt + 4'd1;
`ifdef KEYPAD_REPEAT_EN
                    // Repeat only while the original pattern is still present.
                    if (col_s == pat) begin
                        rpt_cnt_nx = rpt_cnt + 8'd1;
                        if (rpt_cnt_nx == RPT_LIMIT) begin
                            rpt_cnt_nx = 8'd0;
                            valid_nx   = 1'b1;
                        end
                    end else if (pressed) begin
                        rpt_cnt_nx = 8'd0;
                    end
`endif
                    if (rel_cnt_nx == DB_LIMIT) begin
                        held_nx    = 1'b0;
                        state_nx   = SCAN;
                        row_idx_nx = row_idx + 2'd1;
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
        if (accept) begin
            code_nx    = {row_idx, col_index(col_s)};
            valid_nx   = 1'b1;
            held_nx    = 1'b1;
            rel_cnt_nx = 4'd0;
            state_nx   = HELD;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_nx = 8'd0;
`endif
        end
    end

    // Scanner state register; row strobe is registered so it never glitches.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            ROW       <= 4'b1110;
            pat       <= 4'b1111;
            cnt       <= 4'd0;
            rel_cnt   <= 4'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            row_idx   <= row_idx_nx;
            ROW       <= row_decode(row_idx_nx);
            pat       <= pat_nx;
            cnt       <= cnt_nx;
            rel_cnt   <= rel_cnt_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat tick counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) rpt_cnt <= 8'd0;
        else     rpt_cnt <= rpt_cnt_nx;
    end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized keypad stimulus checked against a tick-level
// behavioural model of the scanner (run-length debounce on the frozen row).
module tb_keypad_scan;
    localparam int DB  = 4;
    localparam int RPT = 8;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        clk_e = 1'b0;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c is down

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    int exp_valid = 0;

    // model state
    int   m_r, m_run, m_rel, m_rpt, m_code;
    bit   m_held, exp_pulse;
    logic [3:0] m_pat;

    keypad_scan #(.DEBOUNCE_TICKS(DB), .REPEAT_TICKS(RPT)) dut (
        .clk(clk), .clr(clr), .clk_e(clk_e), .COL(COL),
        .ROW(ROW), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a down key shorts its column to a driven-low row.
    always_comb begin
        COL = 4'b1111;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (!ROW[rr] && keys[rr*4+cc]) COL[cc] = 1'b0;
    end

    always @(negedge clk) if (key_valid === 1'b1) valid_seen++;

    initial begin
        #3ms;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] key_cols(input int row, input logic [15:0] k);
        logic [3:0] c;
        for (int i = 0; i < 4; i++) c[i] = ~k[row*4+i];
        return c;
    endfunction

    function automatic int low_col(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (!s[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_r = 0; m_run = 0; m_rel = 0; m_rpt = 0; m_code = 0;
        m_held = 0; exp_pulse = 0; m_pat = 4'hF;
    endtask

    // One scan tick of the reference behaviour.
    task automatic model_tick();
        logic [3:0] s;
        s = key_cols(m_r, keys);
        exp_pulse = 0;
        if (m_held) begin
            m_rel = (s == 4'hF) ? m_rel + 1 : 0;
`ifdef KEYPAD_REPEAT_EN
            if (s == m_pat) begin
                m_rpt++;
                if (m_rpt == RPT) begin m_rpt = 0; exp_pulse = 1; end
            end else if (s != 4'hF) m_rpt = 0;
`endif
            if (m_rel == DB) begin m_held = 0; m_run = 0; m_r = (m_r + 1) % 4; end
        end else if (s == 4'hF) begin
            m_run = 0;
            m_r = (m_r + 1) % 4;
        end else begin
            if (m_run > 0 && s == m_pat) m_run++;
            else begin m_run = 1; m_pat = s; end
            if (m_run == DB) begin
                m_held = 1; m_rel = 0; m_rpt = 0; m_run = 0;
                m_code = m_r * 4 + low_col(s);
                exp_pulse = 1;
            end
        end
        if (exp_pulse) exp_valid++;
    endtask

    task automatic do_tick(input int hi_cycles);
        logic [3:0] er;
        repeat (3) @(negedge clk);
        clk_e = 1'b1;
        @(posedge clk); #1;
        model_tick();
        for (int i = 0; i < 4; i++) er[i] = (i != m_r);
        check("row", 32'(ROW), 32'(er));
        check("held", 32'(key_held), 32'(m_held));
        check("valid", 32'(key_valid), 32'(exp_pulse));
        check("code", 32'(key_code), 32'(m_code));
        repeat (hi_cycles) @(negedge clk);
        clk_e = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_reset();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(4);
    endtask

    task automatic run_until_held();
        for (int i = 0; i < 24 && !m_held; i++) do_tick(4);
        check("reach_held", 32'(key_held), 32'd1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_row", 32'(ROW), 32'hE);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        clr = 1'b0;

        // idle scan: row walks 1110 -> 1101 -> 1011 -> 0111 -> 1110
        run_ticks(8);
        check("idle_nvalid", 32'(valid_seen), 32'd0);

        // key 6 (row 1, column 2)
        keys = 16'h0040;
        run_until_held();
        check("code6", 32'(key_code), 32'h6);
        keys = 16'h0000;
        run_ticks(DB + 1);
        check("nvalid_k6", 32'(valid_seen), 32'(exp_valid));

        // bounce on key 1 (row 0) toggling every tick
        for (int i = 0; i < 20; i++) begin
            keys = keys ^ 16'h0002;
            do_tick(4);
        end
        keys = 16'h0000;
        run_ticks(4);
        check("nvalid_bounce", 32'(valid_seen), 32'(exp_valid));

        // row 3, columns 0 and 3 together: lowest column wins
        keys = 16'h9000;
        run_until_held();
        check("code_c", 32'(key_code), 32'hC);
        keys = 16'h0000;
        run_ticks(DB + 1);
        // row 3, columns 1 and 3
        keys = 16'hA000;
        run_until_held();
        check("code_d", 32'(key_code), 32'hD);
        keys = 16'h0000;
        run_ticks(DB + 1);

        // clr in the middle of a debounce
        pulse_reset();
        keys = 16'h0002;
        run_ticks(2);
        @(negedge clk); clr = 1'b1; #1;
        check("clr_row", 32'(ROW), 32'hE);
        check("clr_code", 32'(key_code), 32'h0);
        check("clr_valid", 32'(key_valid), 32'h0);
        check("clr_held", 32'(key_held), 32'h0);
        keys = 16'h0000;
        @(negedge clk); clr = 1'b0;
        model_reset();
        run_ticks(3);
        check("nvalid_clr", 32'(valid_seen), 32'(exp_valid));

        // clk_e held high yields a single tick only
        do_tick(30);
        do_tick(4);

        // held key with auto-repeat window of 30 ticks
        keys = 16'h0200;
        run_until_held();
        run_ticks(30);
        check("code9", 32'(key_code), 32'h9);
        check("nvalid_hold", 32'(valid_seen), 32'(exp_valid));
        keys = 16'h0000;
        run_ticks(DB + 2);

        // randomized key activity
        for (int seg = 0; seg < 60; seg++) begin
            int mode, len;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(1, 14);
            case (mode)
                0: keys = 16'h0000;
                1: keys = 16'h0001 << $urandom_range(0, 15);
                2: keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: keys = 16'h0001 << $urandom_range(0, 15);
            endcase
            for (int t = 0; t < len; t++) begin
                do_tick(4);
                if (mode == 3) keys = keys ^ (16'h0001 << $urandom_range(0, 15));
            end
        end
        keys = 16'h0000;
        run_ticks(DB + 4);
        check("nvalid_rand", 32'(valid_seen), 32'(exp_valid));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
